// File: rtl/ff_d_pipe.sv
// ff_d_pipe: enable-gated, flushable WIDTH x DEPTH delay line with per-stage
// valid flags, a runtime output tap and a registered occupancy count.
//
// Ports:
//   CLK     in   clock; rising edge active, falling edge when
//                FF_D_PIPE_NEGEDGE_EN is defined
//   RST     in   asynchronous active-low reset
//   EN      in   advance enable (0 holds all state)
//   CLR     in   synchronous flush, overrides EN
//   D       in   WIDTH data captured into stage 0
//   D_VALID in   valid flag captured with D
//   TAP     in   output stage select (out-of-range selects stage DEPTH-1)
//   Q       out  data of the selected stage
//   Q_VALID out  valid flag of the selected stage
//   OCC     out  registered count of valid stages
//   LAST    out  data of stage DEPTH-1
//
// Build option: FF_D_PIPE_NEGEDGE_EN moves every register to the falling edge.
module ff_d_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TAPW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int OCCW  = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             CLR,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    input  logic [TAPW-1:0]  TAP,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    output logic [OCCW-1:0]  OCC,
    output logic [WIDTH-1:0] LAST
);
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [OCCW-1:0]  occ_q, occ_d;
    logic [TAPW-1:0]  sel;

    always_comb begin
        stage_d = stage_q;
        vld_d   = vld_q;
        occ_d   = occ_q;
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
            vld_d = '0;
            occ_d = '0;
        end else if (EN) begin
            stage_d[0] = D;
            vld_d[0]   = D_VALID;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
                vld_d[i]   = vld_q[i-1];
            end
            // entry and exit in the same edge cancel, so OCC stays in 0..DEPTH
            occ_d = occ_q + OCCW'(D_VALID) - OCCW'(vld_q[DEPTH-1]);
        end
    end

`ifdef FF_D_PIPE_NEGEDGE_EN
    always_ff @(negedge CLK or negedge RST) begin
`else
    always_ff @(posedge CLK or negedge RST) begin
`endif
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            stage_q <= stage_d;
            vld_q   <= vld_d;
            occ_q   <= occ_d;
        end
    end

    // taps beyond the last stage (non-power-of-2 DEPTH) clamp to it
    assign sel     = (int'(TAP) >= DEPTH) ? TAPW'(DEPTH - 1) : TAP;
    assign Q       = stage_q[sel];
    assign Q_VALID = vld_q[sel];
    assign OCC     = occ_q;
    assign LAST    = stage_q[DEPTH-1];
endmodule
